// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL opcodes, channel structs and widths shared by hosts and devices.
package tlul_pkg;
  localparam int TL_AW = 32;
  localparam int TL_DW = 32;
  localparam int TL_DBW = 4;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_HOST_WORD_SIZE = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef logic [13:0] tl_a_user_t;
  localparam tl_a_user_t TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [6:0]        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/tlul_host_bridge_if.sv
// tlul_host_bridge_if: core-side req/gnt/rvalid memory port.
interface tlul_host_bridge_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/tlul_host_bridge.sv
// tlul_host_bridge: core req/gnt/rvalid port to TL-UL host with one A holding beat and rolling source IDs.
// Define TLUL_HOST_SRC_CHECK_EN to flag responses whose d_source differs from the expected in-order ID.
module tlul_host_bridge
  import tlul_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int SrcWidth       = 8
) (
  input  logic              clock,
  input  logic              reset,
  tlul_host_bridge_if.slave core,
  output tl_h2d_t           tl_h_o,
  input  tl_d2h_t           tl_h_i
);
  localparam int IdW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [IdW-1:0] IdLast = IdW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  typedef struct packed {
    tl_a_op_e          opcode;
    logic [IdW-1:0]    source;
    logic [TL_AW-1:0]  address;
    logic [TL_DBW-1:0] mask;
    logic [TL_DW-1:0]  data;
  } a_beat_t;

  function automatic logic [IdW-1:0] id_inc(input logic [IdW-1:0] id);
    return id == IdLast ? '0 : id + 1'b1;
  endfunction

  a_beat_t          a_q, a_d;
  logic             a_pend_q, a_pend_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdW-1:0]   src_nxt_q, src_nxt_d;
  logic             rvalid_q, rvalid_d;
  logic [TL_DW-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             a_fire, d_fire, d_take, src_bad, gnt;
`ifdef TLUL_HOST_SRC_CHECK_EN
  logic [IdW-1:0]   src_exp_q, src_exp_d;
`else
  logic             unused_src;
  assign unused_src = ^tl_h_i.d_source;
`endif
  logic             unused_d;
  assign unused_d = ^{tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink, tl_h_i.d_user};

  // d_ready is tied high, so every d_valid is a d_fire; only counted ones produce a response
  always_comb begin
    a_fire = a_pend_q && tl_h_i.a_ready;
    d_fire = tl_h_i.d_valid;
    d_take = d_fire && cnt_q != '0;
    gnt = !reset && core.req_i && (!a_pend_q || tl_h_i.a_ready) && (cnt_q < CntMax || d_fire);
`ifdef TLUL_HOST_SRC_CHECK_EN
    src_bad = d_take && (SrcWidth'(tl_h_i.d_source) != SrcWidth'(src_exp_q));
    src_exp_d = d_take ? id_inc(src_exp_q) : src_exp_q;
`else
    src_bad = 1'b0;
`endif
    a_d = gnt ? a_beat_t'{
      opcode:  !core.we_i ? Get : (core.be_i == 4'hF ? PutFullData : PutPartialData),
      source:  src_nxt_q,
      address: {core.addr_i[31:2], 2'b00},
      mask:    core.we_i ? core.be_i : 4'hF,
      data:    core.wdata_i
    } : a_q;
    a_pend_d = gnt || (a_pend_q && !a_fire);
    cnt_d = cnt_q + CntW'(gnt) - CntW'(d_take);
    src_nxt_d = gnt ? id_inc(src_nxt_q) : src_nxt_q;
    rvalid_d = d_take;
    rdata_d = (d_take && !src_bad && tl_h_i.d_opcode == AccessAckData) ? tl_h_i.d_data : '0;
    err_d = d_take && (tl_h_i.d_error || src_bad);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q       <= '0;
      a_pend_q  <= 1'b0;
      cnt_q     <= '0;
      src_nxt_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      a_pend_q  <= a_pend_d;
      cnt_q     <= cnt_d;
      src_nxt_q <= src_nxt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef TLUL_HOST_SRC_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) src_exp_q <= '0;
    else src_exp_q <= src_exp_d;
  end
`endif

  always_comb begin
    tl_h_o.a_valid   = a_pend_q;
    tl_h_o.a_opcode  = a_q.opcode;
    tl_h_o.a_param   = '0;
    tl_h_o.a_size    = TL_SZW'(TL_HOST_WORD_SIZE);
    tl_h_o.a_source  = TL_AIW'(SrcWidth'(a_q.source));
    tl_h_o.a_address = a_q.address;
    tl_h_o.a_mask    = a_q.mask;
    tl_h_o.a_data    = a_q.data;
    tl_h_o.a_user    = TL_A_USER_DEFAULT;
    tl_h_o.d_ready   = 1'b1;
  end

  assign core.gnt_o    = gnt;
  assign core.rvalid_o = rvalid_q;
  assign core.rdata_o  = rdata_q;
  assign core.err_o    = err_q;
endmodule

// File: tb/tb_tlul_host_bridge.sv
// tb_tlul_host_bridge: directed tests with a queue-based model of the bridge checked every cycle.
module tb_tlul_host_bridge;
  import tlul_pkg::*;
  localparam int MaxOut = 2;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [7:0]  src;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic a_ready;
  logic rsp_en;
  logic [7:0] src_xor;
  tl_d2h_t drsp;
  tl_h2d_t tl_h_o;
  tl_d2h_t tl_h_i;
  int vectors = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tlul_host_bridge_if core();

  tlul_host_bridge #(.MaxOutstanding(MaxOut), .SrcWidth(8)) dut (
    .clock(clk), .reset(rst), .core(core), .tl_h_o(tl_h_o), .tl_h_i(tl_h_i)
  );

  always_comb begin
    tl_h_i = drsp;
    tl_h_i.a_ready = a_ready;
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return a == 32'h104 ? 32'hDEAD_BEEF : {16'hA5A5, a[15:0]};
  endfunction

  // model: queue of granted-but-unsent beats, outstanding count, source counters
  beat_t aq[$];
  int out_n = 0, src_n = 0, srcexp_n = 0;
  logic exp_rv = 1'b0;
  logic [31:0] exp_rd = '0;
  logic exp_err = 1'b0;

  initial begin
    logic eg, dt;
    beat_t b;
    @(posedge clk);
    forever begin
      @(negedge clk);
      eg = !rst && core.req_i && (aq.size() == 0 || a_ready) && (out_n < MaxOut || tl_h_i.d_valid);
      chk("gnt", core.gnt_o, eg);
      chk("d_ready", tl_h_o.d_ready, 1);
      chk("a_valid", tl_h_o.a_valid, aq.size() != 0);
      if (aq.size() != 0) begin
        chk("a_opcode", tl_h_o.a_opcode, aq[0].op);
        chk("a_address", tl_h_o.a_address, aq[0].addr);
        chk("a_mask", tl_h_o.a_mask, aq[0].mask);
        chk("a_data", tl_h_o.a_data, aq[0].data);
        chk("a_source", tl_h_o.a_source, aq[0].src);
        chk("a_size", tl_h_o.a_size, 2);
        chk("a_param", tl_h_o.a_param, 0);
        chk("a_user", tl_h_o.a_user, 0);
      end
      chk("rvalid", core.rvalid_o, exp_rv);
      if (exp_rv) begin
        chk("rdata", core.rdata_o, exp_rd);
        chk("err", core.err_o, exp_err);
      end
      if (rst) begin
        aq.delete();
        out_n = 0;
        src_n = 0;
        srcexp_n = 0;
        exp_rv = 1'b0;
      end else begin
        dt = tl_h_i.d_valid && out_n > 0;
        if (aq.size() != 0 && a_ready) void'(aq.pop_front());
        if (eg) begin
          b.op = !core.we_i ? 3'h4 : (core.be_i == 4'hF ? 3'h0 : 3'h1);
          b.addr = core.addr_i & 32'hFFFF_FFFC;
          b.mask = core.we_i ? core.be_i : 4'hF;
          b.data = core.wdata_i;
          b.src = 8'(src_n);
          aq.push_back(b);
          src_n = (src_n + 1) % MaxOut;
        end
        out_n = out_n + int'(eg) - int'(dt);
        exp_rv = dt;
        if (dt) begin
          exp_rd = tl_h_i.d_opcode == AccessAckData ? tl_h_i.d_data : 32'h0;
          exp_err = tl_h_i.d_error;
`ifdef TLUL_HOST_SRC_CHECK_EN
          if (int'(tl_h_i.d_source) != srcexp_n) begin
            exp_err = 1'b1;
            exp_rd = 32'h0;
          end
`endif
          srcexp_n = (srcexp_n + 1) % MaxOut;
        end
      end
    end
  end

  // responder: answers fired A beats in order, one cycle later, when rsp_en is set
  beat_t dq[$];
  beat_t a_log[$];

  initial forever begin
    beat_t b;
    @(negedge clk);
    if (!rst && tl_h_o.a_valid && a_ready) begin
      b.op = tl_h_o.a_opcode;
      b.addr = tl_h_o.a_address;
      b.mask = tl_h_o.a_mask;
      b.data = tl_h_o.a_data;
      b.src = tl_h_o.a_source;
      dq.push_back(b);
      a_log.push_back(b);
    end
  end

  initial begin
    drsp = '0;
    forever begin
      @(posedge clk);
      if (drsp.d_valid) void'(dq.pop_front());
      #1;
      if (rsp_en && dq.size() != 0) begin
        drsp.d_valid = 1'b1;
        drsp.d_opcode = dq[0].op == 3'h4 ? AccessAckData : AccessAck;
        drsp.d_source = dq[0].src ^ src_xor;
        drsp.d_data = dq[0].op == 3'h4 ? rd_mem(dq[0].addr) : 32'hBAD0_BAD0;
        drsp.d_error = dq[0].addr == 32'h0BAD_0000;
      end else drsp.d_valid = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    int got;
    got = 0;
    core.we_i = we;
    core.be_i = be;
    core.addr_i = addr;
    core.wdata_i = wd;
    core.req_i = 1'b1;
    for (int i = 0; i < 30 && got == 0; i++) begin
      @(negedge clk);
      if (core.gnt_o) got = 1;
    end
    cyc();
    core.req_i = 1'b0;
    if (got == 0) begin
      vectors++;
      fails++;
      $display("FAIL gnt_timeout: got no grant for addr %0h within 30 cycles", addr);
    end
  endtask

  task automatic wait_rv(output logic [31:0] d, output logic e, output int n);
    int got;
    got = 0;
    n = 0;
    d = '0;
    e = 1'b0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      n++;
      if (core.rvalid_o) begin
        got = 1;
        d = core.rdata_o;
        e = core.err_o;
      end
    end
    if (got == 0) begin
      vectors++;
      fails++;
      $display("FAIL rvalid_timeout: got no rvalid_o within 20 cycles");
    end
    cyc();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic e;
    int n, got;
    rst = 1'b1;
    core.req_i = 1'b0;
    core.we_i = 1'b0;
    core.be_i = '0;
    core.addr_i = '0;
    core.wdata_i = '0;
    a_ready = 1'b1;
    rsp_en = 1'b1;
    src_xor = '0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_gnt", core.gnt_o, 0);
    chk("rst_rvalid", core.rvalid_o, 0);
    chk("rst_rdata", core.rdata_o, 0);
    chk("rst_err", core.err_o, 0);
    chk("rst_a_valid", tl_h_o.a_valid, 0);
    chk("rst_a_address", tl_h_o.a_address, 0);
    chk("rst_d_ready", tl_h_o.d_ready, 1);
    cyc();
    rst = 1'b0;

    a_log.delete();
    issue(1'b0, 4'h0, 32'h0000_0104, 32'h0);
    wait_rv(d, e, n);
    chk("t1_rdata", d, 32'hDEAD_BEEF);
    chk("t1_err", e, 0);
    chk("t1_latency", n, 3);
    chk("t1_op", a_log[0].op, 3'h4);
    chk("t1_addr", a_log[0].addr, 32'h104);
    chk("t1_mask", a_log[0].mask, 4'hF);
    chk("t1_src", a_log[0].src, 0);

    a_log.delete();
    issue(1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678);
    wait_rv(d, e, n);
    chk("t2_rdata", d, 0);
    chk("t2_err", e, 0);
    chk("t2_op", a_log[0].op, 3'h1);
    chk("t2_mask", a_log[0].mask, 4'h3);
    chk("t2_data", a_log[0].data, 32'h1234_5678);

    a_log.delete();
    a_ready = 1'b0;
    issue(1'b1, 4'hF, 32'h0000_0303, 32'hCAFE_F00D);
    core.we_i = 1'b0;
    core.addr_i = 32'h0000_0400;
    core.req_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_gnt_held", core.gnt_o, 0);
      chk("t3_a_valid", tl_h_o.a_valid, 1);
      chk("t3_a_address", tl_h_o.a_address, 32'h300);
      chk("t3_a_opcode", tl_h_o.a_opcode, 3'h0);
      cyc();
    end
    a_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_gnt", core.gnt_o, 1);
    cyc();
    core.req_i = 1'b0;
    repeat (8) cyc();
    chk("t3_first_addr", a_log[0].addr, 32'h300);
    chk("t3_second_addr", a_log[1].addr, 32'h400);

    pulse_rst();
    rsp_en = 1'b0;
    a_log.delete();
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    issue(1'b0, 4'h0, 32'h14, 32'h0);
    core.addr_i = 32'h18;
    core.req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_third_held", core.gnt_o, 0);
      cyc();
    end
    @(negedge clk);
    rsp_en = 1'b1;
    got = 0;
    for (int i = 0; i < 4 && got == 0; i++) begin
      @(negedge clk);
      if (core.gnt_o) got = 1;
    end
    chk("t4_gnt_on_dfire", got, 1);
    cyc();
    core.req_i = 1'b0;
    repeat (8) cyc();
    chk("t4_beats", a_log.size(), 3);
    chk("t4_src0", a_log[0].src, 0);
    chk("t4_src1", a_log[1].src, 1);
    chk("t4_src2", a_log[2].src, 0);

    pulse_rst();
    src_xor = 8'h01;
    issue(1'b0, 4'h0, 32'h104, 32'h0);
    wait_rv(d, e, n);
    src_xor = 8'h00;
`ifdef TLUL_HOST_SRC_CHECK_EN
    chk("t5_err", e, 1);
    chk("t5_rdata", d, 0);
`else
    chk("t5_err", e, 0);
    chk("t5_rdata", d, 32'hDEAD_BEEF);
`endif

    pulse_rst();
    rsp_en = 1'b0;
    issue(1'b0, 4'h0, 32'h40, 32'h0);
    issue(1'b0, 4'h0, 32'h44, 32'h0);
    repeat (2) cyc();
    rst = 1'b1;
    core.addr_i = 32'h20;
    core.req_i = 1'b1;
    cyc();
    @(negedge clk);
    chk("t6_rst_gnt", core.gnt_o, 0);
    chk("t6_rst_a_valid", tl_h_o.a_valid, 0);
    cyc();
    rst = 1'b0;
    core.req_i = 1'b0;
    rsp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_rvalid", core.rvalid_o, 0);
      cyc();
    end

    issue(1'b0, 4'h0, 32'h0000_1001, 32'h0);
    issue(1'b1, 4'hF, 32'h0000_2002, 32'h1111_1111);
    issue(1'b1, 4'h0, 32'h0000_3003, 32'h2222_2222);
    issue(1'b0, 4'h0, 32'h0BAD_0000, 32'h0);
    issue(1'b1, 4'b1000, 32'h0000_4000, 32'h3333_3333);
    issue(1'b0, 4'h0, 32'h0000_0104, 32'h0);
    repeat (10) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
